apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between REQUESTERS independent requesters. Each requester has a simple level request/done interface.
- Round-robin arbitration selects one requester at a time. The block then sequences the APB SETUP/ACCESS phases and returns read data and error status to the winner.
- Sits between on-chip bus clients (bench BFMs, DMA, CPU bridge) and APB4 slaves such as apb4_gpio.

Parameters:
- PADDR_SIZE, 16, APB address width
- PDATA_SIZE, 32, APB data width (multiple of 8)
- REQUESTERS, 2, number of requesters (>=1)
- TIMEOUT, 255, max ACCESS cycles with PREADY low before abort (used only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- req  in  REQUESTERS  per-requester request level; held until matching done
- req_addr  in  REQUESTERS*PADDR_SIZE  flattened addresses; requester i at [i*PADDR_SIZE +: PADDR_SIZE]
- req_write  in  REQUESTERS  1=write, 0=read
- req_strb  in  REQUESTERS*PDATA_SIZE/8  flattened write strobes
- req_wdata  in  REQUESTERS*PDATA_SIZE  flattened write data
- gnt  out  REQUESTERS  one-hot, one-cycle pulse; high during the SETUP cycle of the granted transfer
- done  out  REQUESTERS  one-hot, one-cycle completion pulse
- rdata  out  PDATA_SIZE  read data; valid while done high
- err  out  1  slave error; valid while done high
- busy  out  1  high in SETUP and ACCESS
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  PADDR_SIZE  APB address
- PSTRB  out  PDATA_SIZE/8  APB write strobe
- PWDATA  out  PDATA_SIZE  APB write data
- PRDATA  in  PDATA_SIZE  APB read data
- PREADY, PSLVERR  in  1  APB slave response

Behaviour:
- All outputs are registered.
- Reset (PRESET high at a PCLK edge): state=IDLE. All outputs are 0, including PADDR, PSTRB, PWDATA, PWRITE and rdata. Round-robin pointer last=REQUESTERS-1, so requester 0 wins first.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, pick the first requester with req high, searching upward from last+1 and wrapping modulo REQUESTERS.
  - At the next edge: capture that requester's addr/write/strb/wdata onto PADDR/PWRITE/PSTRB/PWDATA; PSEL=1, PENABLE=0, gnt[i]=1, busy=1, last=i; go to SETUP.
  - For reads, PSTRB=0 and PWDATA=0.
- SETUP: next edge sets PENABLE=1, gnt=0, goes to ACCESS. Unconditional; exactly one cycle.
- ACCESS:
  - While PREADY=0, hold all APB outputs stable.
  - On an edge with PREADY=1: PSEL=0, PENABLE=0, busy=0, done[i]=1, err=PSLVERR; go to DONE.
  - rdata=PRDATA for reads; rdata=0 for writes.
  - PADDR/PSTRB/PWDATA/PWRITE return to 0.
- DONE:
  - One dead cycle. No arbitration. The requester samples done and must deassert req (or present a new transfer) by the following edge.
  - Next edge: done=0, err=0, rdata=0; go to IDLE.
- Throughput: minimum 4 cycles per transfer (IDLE, SETUP, ACCESS, DONE) with zero wait states; +1 cycle per wait state.
- Request inputs are sampled only in IDLE. Changes to req_* of the granted requester after the grant are ignored.
- Simultaneous requests are resolved by round-robin only; no fixed priority beyond the pointer.
- A req that drops while in IDLE before being granted is simply not served. Never drop req after gnt.
- PSLVERR is sampled only with PREADY=1 in ACCESS.
- Reset mid-transfer: at the reset edge, PSEL/PENABLE drop to 0, no done pulse is issued, and the pointer reinitialises.
- REQUESTERS=1: arbiter degenerates to always selecting requester 0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an 8+ bit counter (width $clog2(TIMEOUT+1)) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT with PREADY still 0, the transfer aborts at the next edge: PSEL=0, PENABLE=0, done[i]=1, err=1, rdata=0; go to DONE.
  - PREADY=1 in the same cycle as the limit takes precedence and completes normally.
- Undefined: no counter. ACCESS waits indefinitely for PREADY.

Test Plan:
1. Write, zero wait: req[0]=1, addr=0x0004, strb=0xF, wdata=0xA5A5_0001, PREADY=1 → PSEL high 2 cycles, PENABLE 1 cycle, PWDATA=0xA5A5_0001, done[0] pulse, err=0; 4 cycles req→IDLE.
2. Read, 3 wait states: req[1] read addr=0x0008, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 → APB signals stable throughout, done[1] with rdata=0x1234_5678, total 7 cycles.
3. Contention: req[0] and req[1] both held high for 4 transfers, each dropping req after its done → grant order 0,1,0,1, each gnt one-hot, never overlapping.
4. Error: read with PREADY=1 and PSLVERR=1 → done pulse with err=1. A following clean transfer shows err=0.
5. Reset mid-ACCESS: PRESET high while PREADY=0 → next edge PSEL=PENABLE=0, no done, next grant goes to requester 0.
6. APB_TIMEOUT_EN, TIMEOUT=4, PREADY held 0 → abort after 4 ACCESS cycles: done with err=1, rdata=0, PSEL dropped. Without the macro, the bench sees PSEL held for 100 cycles with no done.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB4 bus bundle between apb_master_arbiter and its slave
interface apb_master_arbiter_if #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one APB4 master port; APB_TIMEOUT_EN adds an ACCESS wait abort
module apb_master_arbiter #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32,
  parameter int REQUESTERS = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                               PCLK,
  input  logic                               PRESET,
  input  logic [REQUESTERS-1:0]              req,
  input  logic [REQUESTERS*PADDR_SIZE-1:0]   req_addr,
  input  logic [REQUESTERS-1:0]              req_write,
  input  logic [REQUESTERS*PDATA_SIZE/8-1:0] req_strb,
  input  logic [REQUESTERS*PDATA_SIZE-1:0]   req_wdata,
  output logic [REQUESTERS-1:0]              gnt,
  output logic [REQUESTERS-1:0]              done,
  output logic [PDATA_SIZE-1:0]              rdata,
  output logic                               err,
  output logic                               busy,
  apb_master_arbiter_if.master               apb
);
  localparam int SW = PDATA_SIZE / 8;
  localparam int LW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]            state;
  logic [LW-1:0]         last;
  logic [LW-1:0]         win;
  logic [LW-1:0]         cand;
  logic                  found;
  logic [PADDR_SIZE-1:0] sel_addr;
  logic                  sel_write;
  logic [SW-1:0]         sel_strb;
  logic [PDATA_SIZE-1:0] sel_wdata;
  logic                  tmo_hit;

  // Search starts just above the last winner and wraps, so the pointer alone sets priority.
  always_comb begin
    win   = last;
    found = 1'b0;
    cand  = last;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand = (cand == LW'(REQUESTERS - 1)) ? '0 : cand + LW'(1);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign sel_addr  = req_addr[int'(win) * PADDR_SIZE +: PADDR_SIZE];
  assign sel_write = req_write[win];
  assign sel_strb  = req_strb[int'(win) * SW +: SW];
  assign sel_wdata = req_wdata[int'(win) * PDATA_SIZE +: PDATA_SIZE];

`ifdef APB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] tmo_cnt;

  // Hit when this PREADY-low cycle is the TIMEOUT-th one spent in ACCESS.
  assign tmo_hit = (state == ST_ACCESS) && !apb.PREADY && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || state != ST_ACCESS) begin
      tmo_cnt <= '0;
    end else if (!apb.PREADY) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      last        <= LW'(REQUESTERS - 1);
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PSTRB   <= '0;
      apb.PWDATA  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            apb.PADDR   <= sel_addr;
            apb.PWRITE  <= sel_write;
            apb.PSTRB   <= sel_write ? sel_strb : '0;
            apb.PWDATA  <= sel_write ? sel_wdata : '0;
            gnt         <= REQUESTERS'(1) << win;
            busy        <= 1'b1;
            last        <= win;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          apb.PENABLE <= 1'b1;
          gnt         <= '0;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready slave wins over a timeout landing on the same cycle.
          if (apb.PREADY || tmo_hit) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PSTRB   <= '0;
            apb.PWDATA  <= '0;
            busy        <= 1'b0;
            done        <= REQUESTERS'(1) << last;
            err         <= apb.PREADY ? apb.PSLVERR : 1'b1;
            rdata       <= (apb.PREADY && !apb.PWRITE) ? apb.PRDATA : '0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= '0;
          err   <= 1'b0;
          rdata <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter (directed vectors)
module tb_apb_master_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int SW = DW / 8;

  typedef struct {
    int          idx;
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } apb_exp_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          psel_n;
    int          pen_n;
  } done_exp_t;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_write;
  logic [NR*SW-1:0] req_strb;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic [DW-1:0]    rdata;
  logic             err;
  logic             busy;

  apb_master_arbiter_if #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) bus ();

  apb_master_arbiter #(
    .PADDR_SIZE(AW),
    .PDATA_SIZE(DW),
    .REQUESTERS(NR),
    .TIMEOUT(4)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .req(req),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_strb(req_strb),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .done(done),
    .rdata(rdata),
    .err(err),
    .busy(busy),
    .apb(bus)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_bad = 0;

  apb_exp_t  apb_q[$];
  done_exp_t done_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_apb(input int idx, input logic wr, input logic [15:0] a,
                                   input logic [3:0] s, input logic [31:0] d);
    apb_exp_t x;
    x.idx = idx; x.wr = wr; x.addr = a; x.strb = s; x.wdata = d;
    apb_q.push_back(x);
  endfunction

  function automatic void push_done(input int idx, input logic [31:0] rd, input logic e,
                                    input int ps, input int pe);
    done_exp_t x;
    x.idx = idx; x.rdata = rd; x.err = e; x.psel_n = ps; x.pen_n = pe;
    done_q.push_back(x);
  endfunction

  // Slave model: PREADY rises after slv_ws ACCESS cycles; drives junk until then.
  int          slv_ws = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;

  initial begin
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'h0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (bus.PSEL && bus.PENABLE && !PRESET) begin
        if (acc_cnt >= slv_ws) begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = slv_rdata;
          bus.PSLVERR = slv_err;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PRDATA  = 32'hDEAD_DEAD;
          bus.PSLVERR = 1'b1;
        end
        acc_cnt++;
      end else begin
        acc_cnt     = 0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'h0;
        bus.PSLVERR = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard at every SETUP cycle and every done pulse.
  int          psel_n = 0;
  int          pen_n = 0;
  logic        stable = 1'b1;
  logic [52:0] snap;
  apb_exp_t    ea;
  done_exp_t   ed;

  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        psel_n = 0;
        pen_n  = 0;
      end else begin
        if (bus.PSEL && !bus.PENABLE) begin
          psel_n = 1;
          pen_n  = 0;
          stable = 1'b1;
          snap   = {bus.PWRITE, bus.PADDR, bus.PSTRB, bus.PWDATA};
          if (apb_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL apb_unexpected: setup at addr %0h with nothing pending", bus.PADDR);
          end else begin
            ea = apb_q.pop_front();
            chk("setup_fields", 64'(snap), 64'({ea.wr, ea.addr, ea.strb, ea.wdata}));
            chk("gnt_onehot", 64'(gnt), 64'(NR'(1) << ea.idx));
          end
        end else if (bus.PSEL) begin
          psel_n++;
          if (bus.PENABLE) pen_n++;
          if ({bus.PWRITE, bus.PADDR, bus.PSTRB, bus.PWDATA} != snap) stable = 1'b0;
        end
        if ((gnt != '0) && !(bus.PSEL && !bus.PENABLE)) begin
          n_vec++; n_bad++;
          $display("FAIL gnt_spurious: gnt=%0h outside SETUP", gnt);
        end
        if (done != '0) begin
          if (done_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL done_unexpected: done=%0h with nothing pending", done);
          end else begin
            ed = done_q.pop_front();
            chk("done_onehot", 64'(done), 64'(NR'(1) << ed.idx));
            chk("rdata", 64'(rdata), 64'(ed.rdata));
            chk("err", 64'(err), 64'(ed.err));
            chk("psel_cycles", 64'(psel_n), 64'(ed.psel_n));
            chk("penable_cycles", 64'(pen_n), 64'(ed.pen_n));
            chk("apb_stable", 64'(stable), 64'(1));
            chk("apb_released", 64'({bus.PSEL, bus.PENABLE, busy, bus.PWRITE, bus.PADDR,
                                     bus.PSTRB, bus.PWDATA}), 64'(0));
          end
        end else if (rdata !== '0 || err !== 1'b0) begin
          n_vec++; n_bad++;
          $display("FAIL result_leak: rdata=%0h err=%0b without done", rdata, err);
        end
      end
    end
  end

  task automatic set_req(input int idx, input logic wr, input logic [15:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    req_write[idx]           = wr;
    req_addr[idx*AW +: AW]   = a;
    req_strb[idx*SW +: SW]   = s;
    req_wdata[idx*DW +: DW]  = d;
  endtask

  task automatic xfer(input int idx, input logic wr, input logic [15:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int ws, input logic [31:0] prd, input logic se,
                      input int acc, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    slv_ws = ws; slv_rdata = prd; slv_err = se;
    set_req(idx, wr, a, s, d);
    push_apb(idx, wr, a, wr ? s : 4'h0, wr ? d : 32'h0);
    push_done(idx, exp_rd, exp_err, acc + 1, acc);
    req[idx] = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (done[idx] !== 1'b1 && n < 200);
    chk("latency", 64'(n), 64'(acc + 2));
    req[idx] = 1'b0;
    @(negedge PCLK);
    chk("idle_after", 64'({busy, bus.PSEL, done}), 64'(0));
  endtask

  task automatic load(input int r, input int j);
    if (r == 0) set_req(0, 1'b1, 16'h0100 + 16'(4 * j), 4'hF, 32'hA000_0000 + 32'(j));
    else        set_req(1, 1'b0, 16'h0200 + 16'(4 * j), 4'h3, 32'h5555_5555);
  endtask

  // Both requesters hold req; each drops for one cycle after its done, then re-presents.
  task automatic contention(input int rounds);
    int served, n;
    int cnt [2];
    logic [1:0] pend;
    slv_ws = 1; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
    for (int j = 0; j < rounds; j++) begin
      push_apb(0, 1'b1, 16'h0100 + 16'(4 * j), 4'hF, 32'hA000_0000 + 32'(j));
      push_done(0, 32'h0, 1'b0, 3, 2);
      push_apb(1, 1'b0, 16'h0200 + 16'(4 * j), 4'h0, 32'h0);
      push_done(1, 32'hCAFE_F00D, 1'b0, 3, 2);
    end
    cnt[0] = 0; cnt[1] = 0; pend = 2'b00;
    load(0, 0); load(1, 0);
    req = 2'b11;
    served = 0; n = 0;
    while (served < 2 * rounds && n < 100 * rounds) begin
      @(negedge PCLK);
      n++;
      for (int r = 0; r < 2; r++) begin
        if (pend[r]) begin
          load(r, cnt[r]);
          req[r]  = 1'b1;
          pend[r] = 1'b0;
        end else if (done[r]) begin
          req[r] = 1'b0;
          served++;
          cnt[r]++;
          if (cnt[r] < rounds) pend[r] = 1'b1;
        end
      end
    end
    chk("contention_served", 64'(served), 64'(2 * rounds));
    @(negedge PCLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n, hold;

  initial begin
    PRESET = 1'b1;
    req = '0; req_addr = '0; req_write = '0; req_strb = '0; req_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_req_side", 64'({gnt, done, rdata, err, busy}), 64'(0));
    chk("reset_apb_side", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PSTRB,
                               bus.PWDATA}), 64'(0));
    PRESET = 1'b0;
    @(negedge PCLK);

    // zero-wait write, then a 3-wait-state read
    xfer(0, 1'b1, 16'h0004, 4'hF, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1, 32'h0, 1'b0);
    xfer(1, 1'b0, 16'h0008, 4'hF, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b0, 4, 32'h1234_5678, 1'b0);

    contention(2);

    // slave error, then a clean write
    xfer(0, 1'b0, 16'h0030, 4'hF, 32'h0, 0, 32'h0BAD_0BAD, 1'b1, 1, 32'h0BAD_0BAD, 1'b1);
    xfer(1, 1'b1, 16'h0034, 4'h5, 32'h7777_8888, 0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b0);

    // reset while requester 0 is stuck in ACCESS
    slv_ws = 1000;
    set_req(0, 1'b0, 16'h0040, 4'hF, 32'h1);
    push_apb(0, 1'b0, 16'h0040, 4'h0, 32'h0);
    req[0] = 1'b1;
    n = 0;
    while (!(bus.PSEL && bus.PENABLE) && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("reach_access", 64'(bus.PSEL && bus.PENABLE), 64'(1));
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    req[0] = 1'b0;
    @(negedge PCLK);
    chk("rst_psel_penable", 64'({bus.PSEL, bus.PENABLE}), 64'(0));
    chk("rst_done_busy_gnt", 64'({done, busy, gnt}), 64'(0));
    PRESET = 1'b0;
    slv_ws = 0;
    @(negedge PCLK);
    contention(1);

`ifdef APB_TIMEOUT_EN
    xfer(1, 1'b0, 16'h0060, 4'hF, 32'h0, 1000, 32'h9999_9999, 1'b0, 4, 32'h0, 1'b1);
`else
    slv_ws = 1000;
    set_req(1, 1'b0, 16'h0060, 4'hF, 32'h0);
    push_apb(1, 1'b0, 16'h0060, 4'h0, 32'h0);
    req[1] = 1'b1;
    n = 0; hold = 0;
    while (n < 110 && hold < 100) begin
      @(negedge PCLK);
      n++;
      if (bus.PSEL && bus.PENABLE && done == '0) hold++;
    end
    chk("no_timeout_hold", 64'(hold), 64'(100));
    PRESET = 1'b1;
    req[1] = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    slv_ws = 0;
    @(negedge PCLK);
`endif

    repeat (3) @(negedge PCLK);
    chk("apb_q_drained", 64'(apb_q.size()), 64'(0));
    chk("done_q_drained", 64'(done_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
